// File: rtl/reg_demux.sv
// reg_demux: routes one upstream register request to one of NUM_SLAVES
// downstream reg_blocks, chosen by addr[SEL_LSB +: SEL_W], and returns that
// slave's completion upstream.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   s_reg_*         : upstream request (req pulse + fields) / response
//                     (ack pulse, err, rdata)
//   m_reg_*         : downstream fields broadcast to all slaves, one-hot req
//                     pulse, per-slave rdata/ack/err
//   busy            : transaction in flight, through the s_reg_ack cycle
//   timeout         : pulses with a completion caused by slave silence
//
// Only one transaction is ever outstanding.  Out-of-range selects complete
// immediately with an error and never reach a slave.
module reg_demux #(
  parameter int REG_ADDR_WIDTH = 16,
  parameter int REG_DATA_WIDTH = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [REG_ADDR_WIDTH-1:0]            s_reg_addr,
  input  logic [REG_DATA_WIDTH-1:0]            s_reg_wdata,
  input  logic                                 s_reg_wren,
  input  logic [REG_DATA_WIDTH/8-1:0]          s_reg_be,
  input  logic                                 s_reg_req,
  output logic [REG_DATA_WIDTH-1:0]            s_reg_rdata,
  output logic                                 s_reg_ack,
  output logic                                 s_reg_err,
  output logic [REG_ADDR_WIDTH-1:0]            m_reg_addr,
  output logic [REG_DATA_WIDTH-1:0]            m_reg_wdata,
  output logic                                 m_reg_wren,
  output logic [REG_DATA_WIDTH/8-1:0]          m_reg_be,
  output logic [NUM_SLAVES-1:0]                m_reg_req,
  input  logic [NUM_SLAVES*REG_DATA_WIDTH-1:0] m_reg_rdata,
  input  logic [NUM_SLAVES-1:0]                m_reg_ack,
  input  logic [NUM_SLAVES-1:0]                m_reg_err,
  output logic                                 busy,
  output logic                                 timeout
);

  localparam int SEL_W = $clog2(NUM_SLAVES);
  localparam int BE_W  = REG_DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      wren_q,  wren_d;
  logic [BE_W-1:0]           be_q,    be_d;
  logic [SEL_W-1:0]          sel_q,   sel_d;
  logic [CNT_W-1:0]          cnt_q,   cnt_d;
  logic [REG_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q,   err_d;
  logic                      to_q,    to_d;

  logic [SEL_W-1:0]          sel_in;
  logic                      sel_ok;
  logic                      ack_hit;
  logic                      err_hit;
  logic [REG_DATA_WIDTH-1:0] rdata_hit;

  assign sel_in = s_reg_addr[SEL_LSB +: SEL_W];
  // Extra bit so the compare also works when NUM_SLAVES is a power of two.
  assign sel_ok = {1'b0, sel_in} < (SEL_W+1)'(NUM_SLAVES);

  // Pick out the selected slave's response; everyone else is ignored.
  always_comb begin
    ack_hit   = 1'b0;
    err_hit   = 1'b0;
    rdata_hit = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        ack_hit   = m_reg_ack[i];
        err_hit   = m_reg_err[i];
        rdata_hit = m_reg_rdata[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wren_d  = wren_q;
    be_d    = be_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (s_reg_req) begin
          addr_d  = s_reg_addr;
          wdata_d = s_reg_wdata;
          wren_d  = s_reg_wren;
          be_d    = s_reg_be;
          sel_d   = sel_in;
          rdata_d = '0;
          to_d    = 1'b0;
          err_d   = ~sel_ok;
          state_d = sel_ok ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE, S_WAIT: begin
        // An ack is honoured even on the expiry cycle, and already in ISSUE
        // for slaves that answer combinationally.
        if (ack_hit) begin
          rdata_d = wren_q ? '0 : rdata_hit;
          err_d   = err_hit;
          to_d    = 1'b0;
          state_d = S_RESP;
        end else if (state_q == S_ISSUE) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else if (cnt_q == CNT_MAX) begin
          rdata_d = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;   // S_RESP: single response cycle
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
      be_q    <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
      be_q    <= be_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    m_reg_req = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      m_reg_req[i] = (state_q == S_ISSUE) && (sel_q == SEL_W'(i));
  end

  // Latched fields stay on the bus between transactions as well.
  assign m_reg_addr  = addr_q;
  assign m_reg_wdata = wdata_q;
  assign m_reg_wren  = wren_q;
  assign m_reg_be    = be_q;

  assign s_reg_ack   = (state_q == S_RESP);
  assign s_reg_err   = s_reg_ack & err_q;
  assign s_reg_rdata = s_reg_ack ? rdata_q : '0;
  assign timeout     = s_reg_ack & to_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_reg_demux.sv
// Randomized scoreboard bench for reg_demux.  The driver pushes the expected
// slave issue and upstream response for each request; a negedge monitor pops
// and compares them whenever the DUT shows m_reg_req or s_reg_ack.
module tb_reg_demux;
  localparam int AW = 16, DW = 32, NS = 4, TO = 16, BW = DW/8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata, s_rdata;
  logic             s_wren, s_req, s_ack, s_err;
  logic [BW-1:0]    s_be;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata;
  logic             m_wren;
  logic [BW-1:0]    m_be;
  logic [NS-1:0]    m_req, m_ack, m_err;
  logic [NS*DW-1:0] m_rdata;
  logic             busy, tmo;

  reg_demux #(.REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW), .NUM_SLAVES(NS),
              .SEL_LSB(12), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .s_reg_addr(s_addr), .s_reg_wdata(s_wdata), .s_reg_wren(s_wren), .s_reg_be(s_be),
    .s_reg_req(s_req), .s_reg_rdata(s_rdata), .s_reg_ack(s_ack), .s_reg_err(s_err),
    .m_reg_addr(m_addr), .m_reg_wdata(m_wdata), .m_reg_wren(m_wren), .m_reg_be(m_be),
    .m_reg_req(m_req), .m_reg_rdata(m_rdata), .m_reg_ack(m_ack), .m_reg_err(m_err),
    .busy(busy), .timeout(tmo));

  // Three-slave instance: select value 3 is out of range here.
  logic [AW-1:0]   s3_addr, d3_maddr;
  logic            s3_req, d3_ack, d3_err, d3_mwren, d3_busy, d3_tmo;
  logic [DW-1:0]   d3_rdata, d3_mwdata;
  logic [BW-1:0]   d3_mbe;
  logic [2:0]      d3_mreq;

  reg_demux #(.REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW), .NUM_SLAVES(3),
              .SEL_LSB(12), .TIMEOUT_CYCLES(TO)) dut3 (
    .clk(clk), .rst(rst),
    .s_reg_addr(s3_addr), .s_reg_wdata('0), .s_reg_wren(1'b0), .s_reg_be('1),
    .s_reg_req(s3_req), .s_reg_rdata(d3_rdata), .s_reg_ack(d3_ack), .s_reg_err(d3_err),
    .m_reg_addr(d3_maddr), .m_reg_wdata(d3_mwdata), .m_reg_wren(d3_mwren), .m_reg_be(d3_mbe),
    .m_reg_req(d3_mreq), .m_reg_rdata('0), .m_reg_ack('0), .m_reg_err('0),
    .busy(d3_busy), .timeout(d3_tmo));

  typedef struct { int cyc; logic [DW-1:0] rdata; logic err; logic to; } resp_t;
  typedef struct { int cyc; logic [NS-1:0] oh; logic [AW-1:0] addr;
                   logic [DW-1:0] wdata; logic [BW-1:0] be; logic wr; } iss_t;
  resp_t rq[$];
  iss_t  iq[$];

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ack"},   s_ack,   0);
    chk({tag, "_s_err"},   s_err,   0);
    chk({tag, "_s_rdata"}, s_rdata, 0);
    chk({tag, "_m_req"},   m_req,   0);
    chk({tag, "_m_wren"},  m_wren,  0);
    chk({tag, "_m_addr"},  m_addr,  0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_m_be"},    m_be,    0);
    chk({tag, "_busy"},    busy,    0);
    chk({tag, "_timeout"}, tmo,     0);
  endtask

  // Monitor / scoreboard
  initial begin
    iss_t  last_iss, i;
    resp_t r;
    logic  prev_ack;
    prev_ack = 1'b0;
    last_iss = '{0, '0, '0, '0, '0, 1'b0};
    forever begin
      @(negedge clk);
      if (prev_ack) chk("busy_after_ack", busy, 0);
      prev_ack = s_ack;
      while (iq.size() > 0 && iq[0].cyc < cyc) begin
        chk("m_req_missing_cycle", cyc, iq[0].cyc);
        void'(iq.pop_front());
      end
      if (m_req != '0) begin
        if (iq.size() == 0) chk("unexpected_m_req", m_req, 0);
        else begin
          i = iq.pop_front();
          chk("m_req_cycle", cyc, i.cyc);
          chk("m_req_onehot", m_req, i.oh);
          chk("m_addr", m_addr, i.addr);
          chk("m_wdata", m_wdata, i.wdata);
          chk("m_be", m_be, i.be);
          chk("m_wren", m_wren, i.wr);
          last_iss = i;
        end
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        chk("ack_missing_cycle", cyc, rq[0].cyc);
        void'(rq.pop_front());
      end
      if (s_ack) begin
        if (rq.size() == 0) chk("unexpected_ack", s_ack, 0);
        else begin
          r = rq.pop_front();
          chk("ack_cycle", cyc, r.cyc);
          chk("ack_rdata", s_rdata, r.rdata);
          chk("ack_err", s_err, r.err);
          chk("ack_timeout", tmo, r.to);
          chk("busy_on_ack", busy, 1);
          // Downstream fields must still hold the issued values.
          chk("hold_addr", m_addr, last_iss.addr);
          chk("hold_wdata", m_wdata, last_iss.wdata);
          chk("hold_be", m_be, last_iss.be);
          chk("hold_wren", m_wren, last_iss.wr);
        end
      end else begin
        chk("rdata_without_ack", s_rdata, 0);
        chk("timeout_without_ack", tmo, 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      s_req = 1'b0; m_ack = '0; m_err = '0;
    end
  endtask

  // d: slave acks d cycles after its m_reg_req cycle (0 = same cycle), -1 = never.
  // spur_at / dup_at: offset after the request cycle for a spurious ack from
  // another slave / an extra s_reg_req; 0 = none, -1 = random.
  task automatic run_txn(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd,
                         input logic [BW-1:0] be, input int d, input logic [DW-1:0] rd,
                         input logic e, input int spur_at_i, input int dup_at_i,
                         input int spur_sl_i);
    int sel, lat, n, spur_sl, spur_at, dup_at;
    resp_t r;
    iss_t  is;
    sel = int'(a[13:12]);
    spur_sl = (spur_sl_i >= 0) ? spur_sl_i : (sel + 1 + int'($urandom_range(0, 2))) % NS;
    if (d >= 0 && d <= TO) begin
      lat = d + 2; r.err = e; r.rdata = wr ? '0 : rd; r.to = 1'b0;
    end else begin
      lat = TO + 2; r.err = 1'b1; r.rdata = '0; r.to = 1'b1;
    end
    spur_at = (spur_at_i < 0) ? int'($urandom_range(1, lat)) : spur_at_i;
    dup_at  = (dup_at_i  < 0) ? int'($urandom_range(1, lat)) : dup_at_i;
    @(posedge clk); #1;
    m_ack = '0; m_err = '0;
    s_addr = a; s_wdata = wd; s_wren = wr; s_be = be; s_req = 1'b1;
    n = cyc;
    r.cyc = n + lat;
    rq.push_back(r);
    is.cyc = n + 1; is.oh = NS'(1) << sel; is.addr = a; is.wdata = wd; is.be = be; is.wr = wr;
    iq.push_back(is);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      s_req = (k == dup_at);
      if (k == dup_at) begin
        s_addr = AW'($urandom); s_wdata = $urandom; s_wren = 1'($urandom); s_be = BW'($urandom);
      end
      m_ack = '0; m_err = '0;
      for (int j = 0; j < NS; j++) m_rdata[j*DW +: DW] = $urandom;
      if (k == spur_at) begin m_ack[spur_sl] = 1'b1; m_err[spur_sl] = 1'b1; end
      if (d >= 0 && k == d + 1) begin
        m_ack[sel] = 1'b1; m_err[sel] = e; m_rdata[sel*DW +: DW] = rd;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; s_req = 1'b0; s_addr = '0; s_wdata = '0; s_wren = 1'b0; s_be = '0;
    m_ack = '0; m_err = '0; m_rdata = '0; s3_req = 1'b0; s3_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1; rst = 1'b0;

    // Decode error on the three-slave instance.
    @(posedge clk); #1; s3_addr = 16'h3000; s3_req = 1'b1;
    @(posedge clk); #1; s3_req = 1'b0;
    @(negedge clk);
    chk("dec_ack", d3_ack, 1);
    chk("dec_err", d3_err, 1);
    chk("dec_rdata", d3_rdata, 0);
    chk("dec_m_req", d3_mreq, 0);
    chk("dec_timeout", d3_tmo, 0);
    @(negedge clk);
    chk("dec_ack_next", d3_ack, 0);
    chk("dec_m_req_next", d3_mreq, 0);
    chk("dec_busy_next", d3_busy, 0);

    // Directed cases.
    run_txn(16'h1004, 1'b0, 32'h0, 4'hF, 3, 32'hCAFE0001, 1'b0, 0, 0, -1);
    run_txn(16'h3008, 1'b1, 32'h12345678, 4'b0011, 4, 32'hDEADBEEF, 1'b0, 0, 0, -1);
    run_txn(16'h2000, 1'b0, 32'h0, 4'hF, -1, 32'h0, 1'b0, 0, 0, -1);
    run_txn(16'h2010, 1'b0, 32'h0, 4'hF, TO, 32'h5A5A0002, 1'b0, 2, 3, 0);
    run_txn(16'h0020, 1'b0, 32'h0, 4'hF, 0, 32'h00C0FFEE, 1'b1, 0, 0, -1);
    idle(2);

    // Reset while waiting; the late ack must not produce a response.
    @(posedge clk); #1;
    s_addr = 16'h2004; s_wdata = 32'h1; s_wren = 1'b0; s_be = 4'hF; s_req = 1'b1;
    n = cyc;
    begin
      iss_t is;
      is.cyc = n + 1; is.oh = 4'b0100; is.addr = 16'h2004; is.wdata = 32'h1; is.be = 4'hF; is.wr = 1'b0;
      iq.push_back(is);
    end
    @(posedge clk); #1; s_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    @(posedge clk); #1; m_ack[2] = 1'b1; m_rdata[2*DW +: DW] = 32'hBAD0BAD0;
    idle(3);
    run_txn(16'h1040, 1'b0, 32'h0, 4'hF, 1, 32'h0BADF00D, 1'b0, 0, 0, -1);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      int d, pick;
      pick = int'($urandom_range(0, 9));
      if (pick == 0)      d = -1;
      else if (pick == 1) d = TO;
      else if (pick == 2) d = TO - 1;
      else                d = int'($urandom_range(0, 6));
      run_txn(AW'($urandom), 1'($urandom), $urandom, BW'($urandom), d, $urandom,
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 1) == 1) ? -1 : 0,
              ($urandom_range(0, 2) == 0) ? -1 : 0, -1);
      idle(int'($urandom_range(0, 2)));
    end
    idle(4);
    chk("resp_pending", rq.size(), 0);
    chk("issue_pending", iq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
